// File: rtl/regfile_sb_pkg.sv
// Shared defaults and address helpers for the regfile_sb register file slice.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_NREG   = 32;
    localparam int unsigned DEF_SP_IDX = 29;
    localparam logic [31:0] DEF_SP_RST = 32'h3ffc;

    // Address width for n registers; never below 1 so ports stay legal for tiny files.
    function automatic int unsigned addr_w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

    // True for addresses that name a real, writable register (r0 is hardwired).
    function automatic logic addr_ok(input int unsigned a, input int unsigned n);
        return (a != 0) && (a < n);
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: issue sets a register's busy bit, writeback clears it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = DEF_NREG,
    localparam int unsigned AW  = addr_w(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_nxt;
    logic            iss_ok;
    logic            clr_ok;

    assign iss_ok = iss_en && addr_ok(32'(iss_addr), NREG);
    assign clr_ok = clr_en && addr_ok(32'(clr_addr), NREG);

    // Set takes priority over a same-cycle clear; bit 0 is never set.
    always_comb begin
        busy_nxt = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            busy_nxt[i] = (iss_ok && (iss_addr == AW'(i))) ||
                          (busy_vec[i] && !(clr_ok && (clr_addr == AW'(i))));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with issue scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned        DATA_W = DEF_DATA_W,
    parameter int unsigned        NREG   = DEF_NREG,
    parameter int unsigned        NRD    = 2,
    parameter int unsigned        SP_IDX = DEF_SP_IDX,
    parameter logic [DATA_W-1:0]  SP_RST = DATA_W'(DEF_SP_RST),
    localparam int unsigned       AW     = addr_w(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [1:0]            wr_en,
    input  logic [2*AW-1:0]       wr_addr,
    input  logic [2*DATA_W-1:0]   wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    output logic [NREG-1:0]       busy_vec
);

    logic [DATA_W-1:0] regs [NREG];

    logic [AW-1:0]     wa0;
    logic [AW-1:0]     wa1;
    logic [DATA_W-1:0] wd0;
    logic [DATA_W-1:0] wd1;
    logic              we0;
    logic              we1;
    logic [AW-1:0]     ra;

    assign wa0 = wr_addr[AW-1:0];
    assign wa1 = wr_addr[2*AW-1:AW];
    assign wd0 = wr_data[DATA_W-1:0];
    assign wd1 = wr_data[2*DATA_W-1:DATA_W];
    assign we0 = wr_en[0] && addr_ok(32'(wa0), NREG);
    assign we1 = wr_en[1] && addr_ok(32'(wa1), NREG);

    // Port 1 is written last so it wins on an address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= ((i == SP_IDX) && (i != 0)) ? SP_RST : '0;
            end
        end else begin
            if (we0) regs[wa0] <= wd0;
            if (we1) regs[wa1] <= wd1;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ra = rd_addr[k*AW +: AW];
            if (addr_ok(32'(ra), NREG)) begin
                rd_data[k*DATA_W +: DATA_W] = regs[ra];
                rd_busy[k]                  = busy_vec[ra];
`ifdef REGFILE_SB_BYPASS_EN
                if (we1 && (wa1 == ra)) begin
                    rd_data[k*DATA_W +: DATA_W] = wd1;
                end else if (we0 && (wa0 == ra)) begin
                    rd_data[k*DATA_W +: DATA_W] = wd0;
                end
                if (we0 && (wa0 == ra)) rd_busy[k] = 1'b0;
`endif
            end
        end
    end

    regfile_scoreboard #(
        .NREG(NREG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .clr_en   (wr_en[0]),
        .clr_addr (wa0),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-style bench for regfile_sb: stimulus queues expectations, negedge monitor checks them.
module tb_regfile_sb;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]      rd_busy;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic [31:0]     busy_vec;

    regfile_sb #(
        .DATA_W(32),
        .NREG  (32),
        .NRD   (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_vec (busy_vec)
    );

    typedef struct packed {
        logic [127:0] name;
        logic [1:0]   kind;   // 0 = rd_data, 1 = rd_busy, 2 = busy_vec
        logic         port;
        logic [31:0]  val;
        logic [31:0]  cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] cyc   = 0;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input logic [127:0] name, input logic [1:0] kind,
                        input logic port, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        e.cyc  = cyc;
        q.push_back(e);
    endtask

    task automatic exp_rd(input logic [127:0] name, input logic port,
                          input logic [31:0] data, input logic busy);
        push(name, 2'd0, port, data);
        push(name, 2'd1, port, {31'b0, busy});
    endtask

    task automatic exp_bv(input logic [127:0] name, input logic [31:0] val);
        push(name, 2'd2, 1'b0, val);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic [1:0] en, input logic [AW-1:0] a0, input logic [31:0] d0,
                      input logic [AW-1:0] a1, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    task automatic iss(input logic [AW-1:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    task automatic idle();
        wr_en  = 2'b00;
        iss_en = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            total++;
            case (e.kind)
                2'd0:    act = e.port ? rd_data[63:32] : rd_data[31:0];
                2'd1:    act = {31'b0, rd_busy[e.port]};
                default: act = busy_vec;
            endcase
            if (e.cyc != cyc) begin
                bad++;
                $display("FAIL %0s: not sampled in its cycle (stamp %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                bad++;
                $display("FAIL %0s: port %0d kind %0d got %h expected %h", e.name, e.port, e.kind, act, e.val);
            end
        end
    end

    initial begin
        reset    = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;

        step(); step();
        rd(5'd29, 5'd0);
        exp_rd("rst_sp", 1'b0, 32'h3ffc, 1'b0);
        exp_rd("rst_r0", 1'b1, 32'h0, 1'b0);
        exp_bv("rst_bv", 32'h0);
        reset = 1'b1;

        for (int unsigned a = 0; a < 32; a += 2) begin
            step();
            rd(5'(a), 5'(a + 1));
            exp_rd("rst_scan", 1'b0, (a == 29) ? 32'h3ffc : 32'h0, 1'b0);
            exp_rd("rst_scan", 1'b1, ((a + 1) == 29) ? 32'h3ffc : 32'h0, 1'b0);
        end
        exp_bv("rst_scan_bv", 32'h0);

        // writeback to r5
        step(); wr(2'b01, 5'd5, 32'hdeadbeef, 5'd0, 32'h0); rd(5'd5, 5'd5);
        exp_rd("wb_same", 1'b0, BYP ? 32'hdeadbeef : 32'h0, 1'b0);
        step(); idle();
        exp_rd("wb_next", 1'b0, 32'hdeadbeef, 1'b0);

        // both ports hit r7
        step(); wr(2'b11, 5'd7, 32'h1, 5'd7, 32'h2); rd(5'd7, 5'd7);
        exp_rd("both7_same", 1'b1, BYP ? 32'h2 : 32'h0, 1'b0);
        step(); idle();
        exp_rd("both7_p0", 1'b0, 32'h2, 1'b0);
        exp_rd("both7_p1", 1'b1, 32'h2, 1'b0);

        // issue r3, writeback two cycles later
        step(); iss(5'd3); rd(5'd3, 5'd3);
        exp_rd("iss3_a", 1'b0, 32'h0, 1'b0); exp_bv("iss3_a_bv", 32'h0);
        step(); idle();
        exp_rd("iss3_b", 1'b0, 32'h0, 1'b1); exp_bv("iss3_b_bv", 32'h8);
        step(); wr(2'b01, 5'd3, 32'h33, 5'd0, 32'h0);
        exp_rd("iss3_c", 1'b1, BYP ? 32'h33 : 32'h0, !BYP); exp_bv("iss3_c_bv", 32'h8);
        step(); idle();
        exp_rd("iss3_d", 1'b0, 32'h33, 1'b0); exp_bv("iss3_d_bv", 32'h0);

        // same-cycle issue + writeback: set wins; re-issue does not count
        step(); iss(5'd3);
        exp_bv("sw_pre0", 32'h0);
        step(); iss(5'd3); wr(2'b01, 5'd3, 32'h44, 5'd0, 32'h0);
        exp_bv("sw_pre1", 32'h8);
        step(); iss(5'd3); wr_en = 2'b00;
        exp_rd("setwin", 1'b0, 32'h44, 1'b1); exp_bv("setwin_bv", 32'h8);
        step(); iss_en = 1'b0; wr(2'b01, 5'd3, 32'h55, 5'd0, 32'h0);
        exp_bv("nocount_bv", 32'h8);
        step(); idle();
        exp_rd("clr3", 1'b0, 32'h55, 1'b0); exp_bv("clr3_bv", 32'h0);

        // port-1 write leaves busy alone
        step(); iss(5'd9); rd(5'd9, 5'd9);
        step(); idle(); wr(2'b10, 5'd0, 32'h0, 5'd9, 32'h99);
        exp_bv("p1_pre_bv", 32'h200);
        step(); idle();
        exp_rd("p1_noclr", 1'b0, 32'h99, 1'b1); exp_bv("p1_noclr_bv", 32'h200);
        step(); wr(2'b01, 5'd9, 32'h9a, 5'd0, 32'h0);
        step(); idle();
        exp_rd("p0_clr9", 1'b0, 32'h9a, 1'b0); exp_bv("p0_clr9_bv", 32'h0);

        // r0 is hardwired
        step(); wr(2'b11, 5'd0, 32'hffffffff, 5'd0, 32'hffffffff); iss(5'd0); rd(5'd0, 5'd0);
        exp_rd("r0_same", 1'b0, 32'h0, 1'b0);
        step(); idle();
        exp_rd("r0_p0", 1'b0, 32'h0, 1'b0);
        exp_rd("r0_p1", 1'b1, 32'h0, 1'b0);
        exp_bv("r0_bv", 32'h0);

        // mid-stream reset with both write ports active
        step(); iss(5'd4);
        step(); iss_en = 1'b0;
        exp_bv("pre_rst_bv", 32'h10);
        step(); wr(2'b11, 5'd5, 32'haaaa, 5'd29, 32'hbbbb); iss(5'd6); rd(5'd7, 5'd4);
        reset = 1'b0;
        exp_rd("rst_async_r7", 1'b0, 32'h0, 1'b0);
        exp_rd("rst_async_r4", 1'b1, 32'h0, 1'b0);
        exp_bv("rst_async_bv", 32'h0);
        step();
        exp_bv("rst_hold_bv", 32'h0);
        idle(); reset = 1'b1; rd(5'd5, 5'd29);
        exp_rd("rst_nowr_r5", 1'b0, 32'h0, 1'b0);
        exp_rd("rst_nowr_sp", 1'b1, 32'h3ffc, 1'b0);
        step(); rd(5'd7, 5'd6);
        exp_rd("rst_r7", 1'b0, 32'h0, 1'b0);
        exp_rd("rst_r6", 1'b1, 32'h0, 1'b0);
        exp_bv("rst_end_bv", 32'h0);

        step(); step();
        if (q.size() != 0) begin
            $display("FAIL leftover: %0d expectations never checked, required 0", q.size());
            bad += q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
